// File: rtl/mem_pkg.sv
// Shared types and widths for the data-memory responder and its word array.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 2;

endpackage

// File: rtl/dmem_array.sv
// Word RAM with a synchronous write port and a combinational read port.
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset, so contents survive a responder reset and
    // the RAM can map onto plain memory macros.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder: fixed-latency response pulse
// after a valid/ready handshake, with alignment and range checking.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W    = $clog2(DEPTH_WORDS);
    localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam logic [WORD_W-1:0] DEPTH_L = WORD_W'(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              acc_err;
    logic              mem_we;
    logic [WORD_W-1:0] arr_rdata;

    // Word index is compared over all upper address bits so aliases above the
    // array are flagged rather than wrapped.
    assign acc_err = (req_addr[OFFSET_W-1:0] != '0) ||
                     ({{OFFSET_W{1'b0}}, req_addr[WORD_W-1:OFFSET_W]} >= DEPTH_L);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (req_addr[IDX_W+OFFSET_W-1:OFFSET_W]),
        .wdata (req_wdata),
        .rdata (arr_rdata)
    );

    // NOTE: state registers use non-blocking assignments only; all next-state
    // arithmetic happens in the combinational block below.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rdata_d = (req_we || acc_err) ? '0 : arr_rdata;
                    err_d   = acc_err;
                    cnt_d   = CNT_W'(CNT_INIT);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err   = rsp_valid & err_q;
        mem_we    = req_valid & req_ready & req_we & ~acc_err;
    end

endmodule
